uart_tx_framer: RTL

//   UART transmit framer driven by an external one-clock baud_tick strobe from the baud rate generator.

---
 rtl/uart_tx_framer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/uart_tx_framer.sv
// UART transmit framer: start, DATA_BITS data (LSB first), optional parity, STOP_BITS stop bits
// on an external baud_tick grid. Define UART_TX_PARITY_EN to add parity (PARITY_ODD selects odd).
module uart_tx_framer #(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 baud_tick,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);
  localparam int               IDX_W     = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SYNC  = 3'd1,
    START = 3'd2,
    DATA  = 3'd3,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd4,
`endif
    STOP  = 3'd5
  } state_t;

  state_t               state_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [IDX_W-1:0]     bit_idx_q;
  logic                 stop_cnt_q;
  logic                 tx_q;
  logic                 ready_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 accept;

  assign accept = tx_valid & ready_q;

`ifdef UART_TX_PARITY_EN
  // Parity is captured with the byte because the shift register is consumed while sending.
  logic par_q;
  logic par_d;
  assign par_d = (^tx_data) ^ (PARITY_ODD != 0);
`else
  logic unused_parity_cfg;
  assign unused_parity_cfg = (PARITY_ODD != 0);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      stop_cnt_q <= 1'b0;
      tx_q       <= 1'b1;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            shift_q <= tx_data;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= SYNC;
          end
        end
        SYNC: begin
          if (baud_tick) begin
            tx_q    <= 1'b0;
            state_q <= START;
          end
        end
        START: begin
          if (baud_tick) begin
            tx_q      <= shift_q[0];
            bit_idx_q <= '0;
            state_q   <= DATA;
          end
        end
        DATA: begin
          if (baud_tick) begin
            if (bit_idx_q < LAST_IDX) begin
              bit_idx_q <= bit_idx_q + IDX_W'(1);
              shift_q   <= shift_q >> 1;
              tx_q      <= shift_q[1];
            end else begin
`ifdef UART_TX_PARITY_EN
              tx_q    <= par_q;
              state_q <= PARITY;
`else
              tx_q       <= 1'b1;
              stop_cnt_q <= 1'b0;
              state_q    <= STOP;
`endif
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (baud_tick) begin
            tx_q       <= 1'b1;
            stop_cnt_q <= 1'b0;
            state_q    <= STOP;
          end
        end
`endif
        STOP: begin
          if (baud_tick) begin
            if (stop_cnt_q == STOP_LAST) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              ready_q <= 1'b1;
            end else begin
              stop_cnt_q <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx       = tx_q;
  assign tx_ready = ready_q;
  assign tx_busy  = busy_q;
  assign tx_done  = done_q;

endmodule
